// File: rtl/regdump_pkg.sv
// Shared state type and default widths for the register-file dump reader and the register file.
package regdump_pkg;

  localparam int REGDUMP_ADDR_W = 5;
  localparam int REGDUMP_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } regdump_state_t;

endpackage : regdump_pkg

// File: rtl/regfile_dump_reader.sv
// Walks register addresses FIRST_REG..LAST_REG through one read port and streams each word with its address.
// Optional build macro REGDUMP_SKIP_ZERO_EN: zero-valued registers are skipped instead of emitted.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int ADDR_W    = REGDUMP_ADDR_W,
  parameter int DATA_W    = REGDUMP_DATA_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  regdump_state_t    state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_last_q, m_last_d;
  logic              m_valid_q, m_valid_d;
  logic              at_last;
  logic              skip_word;

  // LAST_REG ends the walk, so the pointer never has to wrap.
  assign at_last = (ptr_q == LAST_A);

`ifdef REGDUMP_SKIP_ZERO_EN
  assign skip_word = (rd_data == '0);
`else
  assign skip_word = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    m_data_d  = m_data_q;
    m_addr_d  = m_addr_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = FIRST_A;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (skip_word) begin
          if (at_last) state_d = DONE;
          else         ptr_d   = ptr_q + ADDR_W'(1);
        end else begin
          // The word is sampled here; a write landing on this same edge is not seen.
          m_data_d  = rd_data;
          m_addr_d  = ptr_q;
          m_last_d  = at_last;
          m_valid_d = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= FIRST_A;
      m_data_q  <= '0;
      m_addr_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      m_data_q  <= m_data_d;
      m_addr_q  <= m_addr_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rd_addr = ptr_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_addr  = m_addr_q;
  assign m_last  = m_last_q;

endmodule : regfile_dump_reader

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed and randomized dumps against a queue-based model.
// Honours REGDUMP_SKIP_ZERO_EN in the same way as the design.
module tb_regfile_dump_reader;

  localparam int TB_FIRST = 0;
  localparam int TB_LAST  = 31;
`ifdef REGDUMP_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, busy, done, m_valid, m_ready, m_last;
  logic [4:0]  rd_addr, m_addr;
  logic [31:0] rd_data, m_data;
  logic [31:0] mem [32];

  logic        s_start, s_busy, s_done, s_m_valid, s_m_ready, s_m_last;
  logic [4:0]  s_rd_addr, s_m_addr;
  logic [31:0] s_rd_data, s_m_data;
  logic [31:0] mem2 [32];

  int errors = 0;
  int checks = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  int    exp_cycles;

  always #5 clk = ~clk;

  assign rd_data   = mem[rd_addr];
  assign s_rd_data = mem2[s_rd_addr];

  regfile_dump_reader u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_addr  (m_addr),
    .m_last  (m_last)
  );

  regfile_dump_reader #(.FIRST_REG(2), .LAST_REG(2)) u_single (
    .clk     (clk),
    .rst     (rst),
    .start   (s_start),
    .busy    (s_busy),
    .done    (s_done),
    .rd_addr (s_rd_addr),
    .rd_data (s_rd_data),
    .m_valid (s_m_valid),
    .m_ready (s_m_ready),
    .m_data  (s_m_data),
    .m_addr  (s_m_addr),
    .m_last  (s_m_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: every address in range in order, zero words dropped when skipping is enabled.
  // Each emitted word costs 2 cycles, each skipped word 1, plus the start edge.
  task automatic build_expected();
    int skipped = 0;
    exp_q.delete();
    for (int a = TB_FIRST; a <= TB_LAST; a++) begin
      if (SKIP_ZERO && mem[a] == 32'h0) skipped++;
      else exp_q.push_back('{addr: 5'(a), data: mem[a], last: (a == TB_LAST)});
    end
    exp_cycles = 1 + 2 * exp_q.size() + skipped;
  endtask

  // mode 0: m_ready always high, 1: high one cycle in three, 2: random.
  task automatic run_dump(input string name, input int mode, input bit do_start, input bit hold_start);
    beat_t held;
    bit    stalled = 1'b0;
    bit    fin = 1'b0;
    int    cyc = 0;
    build_expected();
    got_q.delete();
    m_ready = (mode == 0);
    if (do_start) begin
      @(negedge clk);
      // NOTE: inputs are driven with blocking assignments on the falling edge, clear of the sampling edge.
      start = 1'b1;
    end
    while (!fin && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (stalled) begin
        check($sformatf("%s_stall_valid", name), 64'(m_valid), 64'd1);
        check($sformatf("%s_stall_beat", name), 64'({m_addr, m_data, m_last}), 64'(held));
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_valid && m_ready) got_q.push_back('{addr: m_addr, data: m_data, last: m_last});
      stalled = m_valid && !m_ready;
      held    = '{addr: m_addr, data: m_data, last: m_last};
      if (done) fin = 1'b1;
    end
    check($sformatf("%s_done_seen", name), 64'(fin), 64'd1);
    if (mode == 0 && do_start) check($sformatf("%s_done_cycle", name), 64'(cyc), 64'(exp_cycles));
    check($sformatf("%s_beat_count", name), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    @(negedge clk);
    check($sformatf("%s_done_one_cycle", name), 64'({done, busy, m_valid}), 64'd0);
  endtask

  initial begin
    int cyc;
    int s_beats;
    bit seen;
    beat_t s_beat;

    rst = 1'b0;
    start = 1'b0;
    m_ready = 1'b0;
    s_start = 1'b0;
    s_m_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 32'(i * 32'h11);
      mem2[i] = 32'h1000 + 32'(i);
    end
    mem2[2] = 32'hDEAD_BEEF;

    #12;
    check("reset_ctrl", 64'({busy, done, m_valid, m_last}), 64'd0);
    check("reset_m_data", 64'(m_data), 64'd0);
    check("reset_m_addr", 64'(m_addr), 64'd0);
    check("reset_rd_addr", 64'(rd_addr), 64'(TB_FIRST));
    check("reset_single_rd_addr", 64'(s_rd_addr), 64'd2);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_dump("full_ready", 0, 1'b1, 1'b0);
    run_dump("one_in_three", 1, 1'b1, 1'b0);

    // start held through the dump: exactly one dump, then IDLE picks start up again.
    run_dump("held_start", 0, 1'b1, 1'b1);
    @(negedge clk);
    check("held_restart_busy", 64'(busy), 64'd1);
    start = 1'b0;
    run_dump("held_second", 0, 1'b0, 1'b0);

    // Reset while SEND holds address 7.
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b1;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (m_valid && m_addr == 5'd7) seen = 1'b1;
    end
    check("rst_reach_addr7", 64'(seen), 64'd1);
    m_ready = 1'b0;
    #1 rst = 1'b0;
    #1 check("rst_mid_dump", 64'({m_valid, busy, done}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("rst_no_done", 64'(seen), 64'd0);
    run_dump("after_rst", 0, 1'b1, 1'b0);

    // Single-register instance: FIRST_REG == LAST_REG == 2.
    @(negedge clk);
    s_start = 1'b1;
    s_beats = 0;
    s_beat = '0;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      s_start = 1'b0;
      if (s_m_valid && s_m_ready) begin
        s_beats++;
        s_beat = '{addr: s_m_addr, data: s_m_data, last: s_m_last};
      end
      if (s_done) seen = 1'b1;
    end
    check("single_done_cycle", 64'(cyc), 64'd3);
    check("single_beats", 64'(s_beats), 64'd1);
    check("single_beat", 64'(s_beat), 64'({5'd2, 32'hDEAD_BEEF, 1'b1}));

    // Sparse file: under zero skipping only addresses 5 and 31 are emitted.
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[5]  = 32'hA5;
    mem[31] = 32'h1;
    run_dump("sparse", 0, 1'b1, 1'b0);
    mem[31] = 32'h0;
    run_dump("sparse_last_zero", 0, 1'b1, 1'b0);
    mem[5] = 32'h0;
    run_dump("all_zero", 0, 1'b1, 1'b0);

    // Randomized contents (about a quarter zero) with random back-pressure.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_dump($sformatf("rand%0d", r), (r == 0) ? 0 : 2, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_dump_reader
